// File: rtl/fp_datapath_sequencer.sv
// fp_datapath_sequencer
// Sequences the 64-bit floating-point datapath for one command at a time.
// It handles ALU, ALU-immediate, 64-bit load and 64-bit store commands.
// Each 64-bit memory transfer is split into two 32-bit beats: the low word first, then the high word.
// Optional feature: define FPSEQ_TIMEOUT_EN to abort a memory beat after TIMEOUT_CYC cycles without MEM_ACK.
// When it is undefined, beats wait indefinitely and o_err stays 0.

module fp_datapath_sequencer #(
  parameter logic [4:0] FS_PASS = 5'd0
`ifdef FPSEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmdValid,
  output logic        o_cmdReady,
  input  logic [1:0]  i_cmdOp,
  input  logic [4:0]  i_cmdFs,
  input  logic [4:0]  i_cmdD,
  input  logic [4:0]  i_cmdS,
  input  logic [4:0]  i_cmdT,
  input  logic [31:0] i_cmdAddr,
  output logic        o_dEn,
  output logic        o_tSel,
  output logic        o_dinSel,
  output logic        o_doutSel,
  output logic        o_ySel,
  output logic [4:0]  o_fs,
  output logic [4:0]  o_dAddr,
  output logic [4:0]  o_sAddr,
  output logic [4:0]  o_tAddr,
  output logic        o_memRd,
  output logic        o_memWr,
  output logic [31:0] o_memAddr,
  input  logic        i_memAck,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_LD_LO,
    S_LD_HI,
    S_LD_WB,
    S_ST_EVAL,
    S_ST_LO,
    S_ST_HI
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_ready;
  logic [1:0]  r_cmdOp;
  logic [4:0]  r_cmdFs;
  logic [4:0]  r_cmdD;
  logic [4:0]  r_cmdS;
  logic [4:0]  r_cmdT;
  logic [31:0] r_cmdAddr;
  logic [31:0] w_addrHi;
  logic        w_accept;
  logic        w_timeout;

  // r_ready keeps CMD_READY low while in reset and through the cycle in which reset is released.
  assign o_cmdReady = r_ready && (r_state == S_IDLE);
  assign w_accept   = i_cmdValid && o_cmdReady;
  assign w_addrHi   = r_cmdAddr + 32'd4;

`ifdef FPSEQ_TIMEOUT_EN
  logic [15:0] r_waitCnt;
  logic        w_inBeat;

  assign w_inBeat  = (r_state == S_LD_LO) || (r_state == S_LD_HI) ||
                     (r_state == S_ST_LO) || (r_state == S_ST_HI);
  assign w_timeout = w_inBeat && ({16'd0, r_waitCnt} == TIMEOUT_CYC);

  // Wait counter: cleared on every state change (so on entry to each beat), counts idle beat cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_waitCnt <= '0;
    end else if (w_nextState != r_state) begin
      r_waitCnt <= '0;
    end else if (w_inBeat) begin
      r_waitCnt <= r_waitCnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register and the ready flag that rises on the first edge after reset is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ready <= 1'b1;
    end
  end

  // Latch every command field on accept, so the command stays stable while the sequencer is busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmdOp   <= '0;
      r_cmdFs   <= '0;
      r_cmdD    <= '0;
      r_cmdS    <= '0;
      r_cmdT    <= '0;
      r_cmdAddr <= '0;
    end else if (w_accept) begin
      r_cmdOp   <= i_cmdOp;
      r_cmdFs   <= i_cmdFs;
      r_cmdD    <= i_cmdD;
      r_cmdS    <= i_cmdS;
      r_cmdT    <= i_cmdT;
      r_cmdAddr <= i_cmdAddr;
    end
  end

  // Next-state and datapath control decode. Every control line is 0 outside a command.
  always_comb begin
    w_nextState = r_state;
    o_dEn       = 1'b0;
    o_tSel      = 1'b0;
    o_dinSel    = 1'b0;
    o_doutSel   = 1'b0;
    o_ySel      = 1'b0;
    o_fs        = '0;
    o_dAddr     = '0;
    o_sAddr     = '0;
    o_tAddr     = '0;
    o_memRd     = 1'b0;
    o_memWr     = 1'b0;
    o_memAddr   = '0;
    o_done      = 1'b0;
    o_err       = 1'b0;

    if (r_state != S_IDLE) begin
      o_fs    = r_cmdFs;
      o_dAddr = r_cmdD;
      o_sAddr = r_cmdS;
      o_tAddr = r_cmdT;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (i_cmdOp)
            2'b00, 2'b01: w_nextState = S_EXEC;
            2'b10:        w_nextState = S_LD_LO;
            default:      w_nextState = S_ST_EVAL;
          endcase
        end
      end

      S_EXEC: begin
        o_dEn       = 1'b1;
        o_tSel      = r_cmdOp[0];
        o_done      = 1'b1;
        w_nextState = S_IDLE;
      end

      S_LD_LO: begin
        if (w_timeout) begin
          o_err       = 1'b1;
          w_nextState = S_IDLE;
        end else begin
          o_memRd   = 1'b1;
          o_memAddr = r_cmdAddr;
          if (i_memAck) begin
            w_nextState = S_LD_HI;
          end
        end
      end

      S_LD_HI: begin
        o_dinSel = 1'b1;
        if (w_timeout) begin
          o_err       = 1'b1;
          w_nextState = S_IDLE;
        end else begin
          o_memRd   = 1'b1;
          o_memAddr = w_addrHi;
          if (i_memAck) begin
            w_nextState = S_LD_WB;
          end
        end
      end

      S_LD_WB: begin
        o_dEn       = 1'b1;
        o_ySel      = 1'b1;
        o_dinSel    = 1'b1;
        o_done      = 1'b1;
        w_nextState = S_IDLE;
      end

      S_ST_EVAL: begin
        o_fs        = FS_PASS;
        w_nextState = S_ST_LO;
      end

      S_ST_LO: begin
        o_fs = FS_PASS;
        if (w_timeout) begin
          o_err       = 1'b1;
          w_nextState = S_IDLE;
        end else begin
          o_memWr   = 1'b1;
          o_memAddr = r_cmdAddr;
          if (i_memAck) begin
            w_nextState = S_ST_HI;
          end
        end
      end

      S_ST_HI: begin
        o_fs = FS_PASS;
        if (w_timeout) begin
          o_err       = 1'b1;
          w_nextState = S_IDLE;
        end else begin
          o_memWr   = 1'b1;
          o_doutSel = 1'b1;
          o_memAddr = w_addrHi;
          if (i_memAck) begin
            o_done      = 1'b1;
            w_nextState = S_IDLE;
          end
        end
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_datapath_sequencer.sv
// tb_fp_datapath_sequencer
// Directed bench for fp_datapath_sequencer.
// It includes a small behavioural datapath: a regfile, the DIN and Y buffers, and the memory data path.
// This model lets the bench check load write-back and store data as well as the control lines.
// Define FPSEQ_TIMEOUT_EN to build the timeout variant with TIMEOUT_CYC=4.

module tb_fp_datapath_sequencer;

  localparam logic [9:0] C_DEN     = 10'h200;
  localparam logic [9:0] C_TSEL    = 10'h100;
  localparam logic [9:0] C_DINSEL  = 10'h080;
  localparam logic [9:0] C_DOUTSEL = 10'h040;
  localparam logic [9:0] C_YSEL    = 10'h020;
  localparam logic [9:0] C_MEMRD   = 10'h010;
  localparam logic [9:0] C_MEMWR   = 10'h008;
  localparam logic [9:0] C_DONE    = 10'h004;
  localparam logic [9:0] C_ERR     = 10'h002;
  localparam logic [9:0] C_RDY     = 10'h001;

  logic        clk;
  logic        rstN;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [4:0]  cmdFs;
  logic [4:0]  cmdD;
  logic [4:0]  cmdS;
  logic [4:0]  cmdT;
  logic [31:0] cmdAddr;
  logic        dEn;
  logic        tSel;
  logic        dinSel;
  logic        doutSel;
  logic        ySel;
  logic [4:0]  fs;
  logic [4:0]  dAddr;
  logic [4:0]  sAddr;
  logic [4:0]  tAddr;
  logic        memRd;
  logic        memWr;
  logic [31:0] memAddr;
  logic        memAck;
  logic        done;
  logic        err;
  logic [31:0] dy;

  logic [63:0] regFile [32];
  logic [31:0] dinLo;
  logic [31:0] dinHi;
  logic [31:0] yLo;
  logic [31:0] yHi;
  logic [31:0] dout;

  int totalChecks = 0;
  int badChecks   = 0;

  fp_datapath_sequencer #(
    .FS_PASS(5'd0)
`ifdef FPSEQ_TIMEOUT_EN
    , .TIMEOUT_CYC(4)
`endif
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_cmdValid (cmdValid),
    .o_cmdReady (cmdReady),
    .i_cmdOp    (cmdOp),
    .i_cmdFs    (cmdFs),
    .i_cmdD     (cmdD),
    .i_cmdS     (cmdS),
    .i_cmdT     (cmdT),
    .i_cmdAddr  (cmdAddr),
    .o_dEn      (dEn),
    .o_tSel     (tSel),
    .o_dinSel   (dinSel),
    .o_doutSel  (doutSel),
    .o_ySel     (ySel),
    .o_fs       (fs),
    .o_dAddr    (dAddr),
    .o_sAddr    (sAddr),
    .o_tAddr    (tAddr),
    .o_memRd    (memRd),
    .o_memWr    (memWr),
    .o_memAddr  (memAddr),
    .i_memAck   (memAck),
    .o_done     (done),
    .o_err      (err)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural datapath. DIN buffers capture DY on a read ack. The regfile is written on D_EN.
  // The Y buffers follow the selected S register while the pass-through function is selected.
  always @(posedge clk) begin
    if (memRd && memAck) begin
      if (dinSel) dinHi <= dy;
      else        dinLo <= dy;
    end
    if (dEn) begin
      regFile[dAddr] <= ySel ? {dinHi, dinLo} : 64'hDEAD_DEAD_DEAD_DEAD;
    end
    if (fs == 5'd0 && !dEn) begin
      yHi <= regFile[sAddr][63:32];
      yLo <= regFile[sAddr][31:0];
    end
  end

  assign dout = doutSel ? yHi : yLo;

  function automatic logic [9:0] getCtl();
    return {dEn, tSel, dinSel, doutSel, ySel, memRd, memWr, done, err, cmdReady};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [4:0] f,
                               input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                               input logic [31:0] a);
    cmdValid = v;
    cmdOp    = op;
    cmdFs    = f;
    cmdD     = d;
    cmdS     = s;
    cmdT     = t;
    cmdAddr  = a;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regFile[i] = 64'(i);
    regFile[5]  = 64'h1122_3344_5566_7788;
    regFile[11] = 64'h0000_0000_0BAD_F00D;
    dinLo  = '0;
    dinHi  = '0;
    yLo    = '0;
    yHi    = '0;
    memAck = 1'b0;
    dy     = '0;
    rstN   = 1'b0;
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);

    // Reset: everything low, ready rises only on the first edge after release.
    cycle();
    cycle();
    checkOutput("resetCtl", 64'(getCtl()), 64'(10'h000));
    checkOutput("resetAddr", {27'd0, dAddr, memAddr}, 64'd0);
    rstN = 1'b1;
    #1;
    checkOutput("releaseNotReady", 64'(getCtl()), 64'(10'h000));
    cycle();
    checkOutput("readyAfterRelease", 64'(getCtl()), 64'(C_RDY));

    // ALU op: FS=3, D=4, S=1, T=2.
    applyStimulus(1'b1, 2'b00, 5'd3, 5'd4, 5'd1, 5'd2, 32'd0);
    cycle();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #1;
    checkOutput("aluExecCtl", 64'(getCtl()), 64'(C_DEN | C_DONE));
    checkOutput("aluExecAddr", {44'd0, fs, dAddr, sAddr, tAddr}, {44'd0, 5'd3, 5'd4, 5'd1, 5'd2});
    cycle();
    checkOutput("aluReadyBack", 64'(getCtl()), 64'(C_RDY));

    // ALU-immediate op selects T from DT.
    applyStimulus(1'b1, 2'b01, 5'd6, 5'd8, 5'd9, 5'd10, 32'd0);
    cycle();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #1;
    checkOutput("aluImmExecCtl", 64'(getCtl()), 64'(C_DEN | C_TSEL | C_DONE));
    checkOutput("aluImmDAddr", 64'(dAddr), 64'd8);
    cycle();
    checkOutput("aluImmReadyBack", 64'(getCtl()), 64'(C_RDY));

    // An ack outside a beat is ignored.
    memAck = 1'b1;
    #1;
    checkOutput("strayAckIdle", 64'(getCtl()), 64'(C_RDY));
    cycle();
    memAck = 1'b0;
    #1;
    checkOutput("strayAckStillIdle", {22'd0, getCtl(), memAddr}, {22'd0, C_RDY, 32'd0});

    // LOAD ADDR=0x100, D=7, two wait cycles before each ack.
    applyStimulus(1'b1, 2'b10, 5'd0, 5'd7, 5'd0, 5'd0, 32'h0000_0100);
    cycle();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      memAck = (i == 2);
      dy     = 32'hAAAA_0001;
      #1;
      checkOutput("loadLoBeat", {22'd0, getCtl(), memAddr}, {22'd0, C_MEMRD, 32'h0000_0100});
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      memAck = (i == 2);
      dy     = 32'hBBBB_0002;
      #1;
      checkOutput("loadHiBeat", {22'd0, getCtl(), memAddr}, {22'd0, C_MEMRD | C_DINSEL, 32'h0000_0104});
      cycle();
    end
    memAck = 1'b0;
    #1;
    checkOutput("loadWbCtl", 64'(getCtl()), 64'(C_DEN | C_YSEL | C_DINSEL | C_DONE));
    checkOutput("loadWbDAddr", 64'(dAddr), 64'd7);
    cycle();
    checkOutput("loadReadyBack", 64'(getCtl()), 64'(C_RDY));
    checkOutput("loadReg7", regFile[7], 64'hBBBB_0002_AAAA_0001);

    // STORE S=5 with zero-wait acks; FS from the command must be overridden by FS_PASS.
    applyStimulus(1'b1, 2'b11, 5'd9, 5'd2, 5'd5, 5'd6, 32'h0000_0200);
    cycle();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #1;
    checkOutput("storeEvalCtl", 64'(getCtl()), 64'(10'h000));
    checkOutput("storeEvalFsS", {54'd0, fs, sAddr}, {54'd0, 5'd0, 5'd5});
    cycle();
    memAck = 1'b1;
    #1;
    checkOutput("storeLoBeat", {22'd0, getCtl(), memAddr}, {22'd0, C_MEMWR, 32'h0000_0200});
    checkOutput("storeLoData", 64'(dout), 64'h5566_7788);
    cycle();
    checkOutput("storeHiBeat", {22'd0, getCtl(), memAddr}, {22'd0, C_MEMWR | C_DOUTSEL | C_DONE, 32'h0000_0204});
    checkOutput("storeHiData", 64'(dout), 64'h1122_3344);
    checkOutput("storeFsHeld", {54'd0, fs, sAddr}, {54'd0, 5'd0, 5'd5});
    cycle();
    memAck = 1'b0;
    #1;
    checkOutput("storeReadyBack", 64'(getCtl()), 64'(C_RDY));

    // Wrapping LOAD at 0xFFFFFFFC while a second command is held valid during the beats.
    applyStimulus(1'b1, 2'b10, 5'd0, 5'd9, 5'd0, 5'd0, 32'hFFFF_FFFC);
    cycle();
    applyStimulus(1'b1, 2'b00, 5'd1, 5'd3, 5'd1, 5'd1, 32'h0000_0040);
    memAck = 1'b1;
    dy     = 32'hCAFE_0001;
    #1;
    checkOutput("wrapLoBeat", {22'd0, getCtl(), memAddr}, {22'd0, C_MEMRD, 32'hFFFF_FFFC});
    cycle();
    memAck = 1'b0;
    #1;
    checkOutput("wrapHiBeat", {22'd0, getCtl(), memAddr}, {22'd0, C_MEMRD | C_DINSEL, 32'h0000_0000});
    checkOutput("wrapHeldDAddr", 64'(dAddr), 64'd9);
    cycle();
    memAck = 1'b1;
    dy     = 32'hCAFE_0002;
    #1;
    checkOutput("wrapHiBeatAck", {22'd0, getCtl(), memAddr}, {22'd0, C_MEMRD | C_DINSEL, 32'h0000_0000});
    cycle();
    memAck = 1'b0;
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #1;
    checkOutput("wrapWbCtl", {49'd0, getCtl(), dAddr}, {49'd0, C_DEN | C_YSEL | C_DINSEL | C_DONE, 5'd9});
    cycle();
    checkOutput("wrapReadyBack", 64'(getCtl()), 64'(C_RDY));
    checkOutput("wrapReg9", regFile[9], 64'hCAFE_0002_CAFE_0001);

    // Reset asserted during LD_HI aborts the load with no regfile write.
    applyStimulus(1'b1, 2'b10, 5'd0, 5'd11, 5'd0, 5'd0, 32'h0000_0300);
    cycle();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    memAck = 1'b1;
    dy     = 32'h1234_5678;
    cycle();
    memAck = 1'b0;
    #1;
    checkOutput("abortHiBeat", {22'd0, getCtl(), memAddr}, {22'd0, C_MEMRD | C_DINSEL, 32'h0000_0304});
    rstN   = 1'b0;
    memAck = 1'b1;
    #1;
    checkOutput("abortResetCtl", 64'(getCtl()), 64'(10'h000));
    checkOutput("abortResetAddr", {27'd0, dAddr, memAddr}, 64'd0);
    cycle();
    memAck = 1'b0;
    rstN   = 1'b1;
    #1;
    checkOutput("abortReleaseNotReady", 64'(getCtl()), 64'(10'h000));
    cycle();
    checkOutput("abortReadyAfterRelease", 64'(getCtl()), 64'(C_RDY));
    checkOutput("abortReg11Kept", regFile[11], 64'h0000_0000_0BAD_F00D);

`ifdef FPSEQ_TIMEOUT_EN
    // STORE whose low beat never acks: four request cycles, then a lone ERR pulse.
    applyStimulus(1'b1, 2'b11, 5'd0, 5'd0, 5'd5, 5'd0, 32'h0000_0400);
    cycle();
    applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      checkOutput("timeoutWaitBeat", 64'(getCtl()), 64'(C_MEMWR));
      cycle();
    end
    checkOutput("timeoutErrPulse", 64'(getCtl()), 64'(C_ERR));
    cycle();
    checkOutput("timeoutReadyBack", 64'(getCtl()), 64'(C_RDY));
`else
    // Without the timeout option a beat waits as long as needed and ERR never rises.
    begin
      int heldCycles;
      heldCycles = 0;
      applyStimulus(1'b1, 2'b11, 5'd0, 5'd0, 5'd5, 5'd0, 32'h0000_0400);
      cycle();
      applyStimulus(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      cycle();
      for (int i = 0; i < 300; i++) begin
        if (memWr && !err) heldCycles++;
        cycle();
      end
      checkOutput("longWaitHeld", 64'(heldCycles), 64'd300);
      memAck = 1'b1;
      #1;
      checkOutput("longWaitLoAck", {22'd0, getCtl(), memAddr}, {22'd0, C_MEMWR, 32'h0000_0400});
      cycle();
      checkOutput("longWaitHiAck", 64'(getCtl()), 64'(C_MEMWR | C_DOUTSEL | C_DONE));
      cycle();
      memAck = 1'b0;
      #1;
      checkOutput("longWaitReadyBack", 64'(getCtl()), 64'(C_RDY));
    end
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
